// File: rtl/axi_multi_id_rd_engine.sv
// Multi-ID AXI4 read engine: issues a run of INCR read bursts with up to
// MAX_OUTSTANDING IDs in flight, tracks returning R beats per ID and flags
// bad responses and protocol errors without aborting the run.
module axi_multi_id_rd_engine #(
  parameter int ID_WIDTH        = 5,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 1024,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            engine_start_pulse,
  input  logic [ADDR_WIDTH-1:0]           source_address,
  input  logic [7:0]                      burst_len,
  input  logic [31:0]                     rd_number,
  input  logic                            wrap_mode,
  input  logic [3:0]                      wrap_len,
  output logic [ID_WIDTH-1:0]             m_axi_arid,
  output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [ID_WIDTH-1:0]             m_axi_rid,
  input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic                            busy,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                            rd_done_pulse,
  output logic [1:0]                      rd_error,
  output logic [63:0]                     rd_error_info
);

  localparam int IDX_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, stride_q, next_addr_q;
  logic [7:0]             burst_len_q;
  logic [31:0]            rd_number_q, issued_q;
  logic                   wrap_mode_q;
  logic [3:0]             wrap_len_q;
  logic [15:0]            wrap_cnt_q;
  logic [OUT_W-1:0]       outstanding_q;
  logic                   hold_q;
  logic [IDX_W-1:0]       hold_idx_q;
  logic [1:0]             rd_error_q;
  logic [63:0]            rd_error_info_q;

  logic [MAX_OUTSTANDING-1:0] free_vec;
  logic [7:0]                 beat_cnt [MAX_OUTSTANDING];
  logic                       free_any;
  logic [IDX_W-1:0]           low_idx, ar_idx, r_idx;
  logic                       start_acc, run_active, arvalid, ar_hs;
  logic                       rid_in_range, rid_live, r_beat, r_hit, r_release, wrap_last;
  logic [1:0]                 err_new;
  logic                       unused_ok;

  assign start_acc    = (state_q == IDLE) && engine_start_pulse;
  assign run_active   = (state_q == ISSUE) || (state_q == DRAIN);

  // Once an AR is shown but not accepted its ID is frozen, so later frees of
  // lower IDs cannot change arid mid-handshake; araddr only moves on a handshake.
  assign ar_idx       = hold_q ? hold_idx_q : low_idx;
  assign arvalid      = (state_q == ISSUE) && (hold_q || (free_any && (issued_q < rd_number_q)));
  assign ar_hs        = arvalid && m_axi_arready;

  // R beats are always accepted; they only count or flag errors during a run,
  // so stale beats after a reset are silently swallowed.
  assign rid_in_range = 32'(m_axi_rid) < MAX_OUTSTANDING;
  assign r_idx        = m_axi_rid[IDX_W-1:0];
  assign rid_live     = rid_in_range && !free_vec[r_idx];
  assign r_beat       = m_axi_rvalid && run_active;
  assign r_hit        = r_beat && rid_live;
  assign r_release    = r_hit && m_axi_rlast;
  assign err_new[0]   = r_beat && (m_axi_rresp != 2'b00);
  assign err_new[1]   = r_beat && (!rid_live || (m_axi_rlast && (beat_cnt[r_idx] != burst_len_q)));
  assign wrap_last    = wrap_mode_q && (wrap_cnt_q == ((16'd1 << wrap_len_q) - 16'd1));

  // Per-ID allocation flag and beat counter.
  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_id
    logic       free_q;
    logic [7:0] beat_q;
    // Allocate on AR handshake, count beats, free on rlast.
    always_ff @(posedge clk) begin
      if (rst || start_acc) begin
        free_q <= 1'b1;
        beat_q <= '0;
      end else if (ar_hs && (ar_idx == IDX_W'(gi))) begin
        free_q <= 1'b0;
        beat_q <= '0;
      end else if (r_hit && (r_idx == IDX_W'(gi))) begin
        beat_q <= beat_q + 8'd1;
        if (m_axi_rlast) free_q <= 1'b1;
      end
    end
    assign free_vec[gi] = free_q;
    assign beat_cnt[gi] = beat_q;
  end

  // Lowest free ID from the registered bitmap.
  always_comb begin
    free_any = |free_vec;
    low_idx  = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (free_vec[i]) low_idx = IDX_W'(i);
    end
  end

  // Run sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (engine_start_pulse) state_d = ISSUE;
      ISSUE: begin
        if (rd_number_q == 32'd0)          state_d = DONE;
        else if (issued_q == rd_number_q)  state_d = DRAIN;
      end
      DRAIN: if (outstanding_q == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Configuration capture, issue bookkeeping, in-flight count and error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      base_q          <= '0;
      stride_q        <= '0;
      next_addr_q     <= '0;
      burst_len_q     <= '0;
      rd_number_q     <= '0;
      wrap_mode_q     <= 1'b0;
      wrap_len_q      <= '0;
      wrap_cnt_q      <= '0;
      issued_q        <= '0;
      outstanding_q   <= '0;
      hold_q          <= 1'b0;
      hold_idx_q      <= '0;
      rd_error_q      <= '0;
      rd_error_info_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        base_q          <= source_address;
        stride_q        <= ADDR_WIDTH'({1'b0, burst_len} + 9'd1) << SIZE_LOG2;
        next_addr_q     <= source_address;
        burst_len_q     <= burst_len;
        rd_number_q     <= rd_number;
        wrap_mode_q     <= wrap_mode;
        wrap_len_q      <= wrap_len;
        wrap_cnt_q      <= '0;
        issued_q        <= '0;
        outstanding_q   <= '0;
        hold_q          <= 1'b0;
        rd_error_q      <= '0;
        rd_error_info_q <= '0;
      end else begin
        hold_q     <= arvalid && !m_axi_arready;
        hold_idx_q <= ar_idx;
        if (ar_hs) begin
          issued_q <= issued_q + 32'd1;
          if (wrap_last) begin
            next_addr_q <= base_q;
            wrap_cnt_q  <= '0;
          end else begin
            next_addr_q <= next_addr_q + stride_q;
            wrap_cnt_q  <= wrap_cnt_q + 16'd1;
          end
        end
        case ({ar_hs, r_release})
          2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
          2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
          default: outstanding_q <= outstanding_q;
        endcase
        rd_error_q <= rd_error_q | err_new;
        if ((rd_error_q == 2'b00) && (err_new != 2'b00)) begin
          rd_error_info_q <= {16'(m_axi_rid), 16'(m_axi_rresp), issued_q};
        end
      end
    end
  end

  assign m_axi_arid    = ID_WIDTH'(ar_idx);
  assign m_axi_araddr  = next_addr_q;
  assign m_axi_arlen   = burst_len_q;
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid;
  assign m_axi_rready  = 1'b1;
  assign busy          = run_active;
  assign outstanding   = outstanding_q;
  assign rd_done_pulse = (state_q == DONE);
  assign rd_error      = rd_error_q;
  assign rd_error_info = rd_error_info_q;
  assign unused_ok     = ^m_axi_rdata;

endmodule

// File: doc/axi_multi_id_rd_engine.md
AXI_MULTI_ID_RD_ENGINE -- requirements
Module: axi_multi_id_rd_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ID_WIDTH, 5, AXI ID width.
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 1024, AXI data width; power of 2, 32..1024.
- MAX_OUTSTANDING, 8, concurrent in-flight bursts; power of 2, at most 2^ID_WIDTH.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- engine_start_pulse, in, 1, start one run.
- source_address, in, ADDR_WIDTH, base byte address.
- burst_len, in, 8, beats per burst minus 1.
- rd_number, in, 32, bursts per run.
- wrap_mode, in, 1, enable address wrap.
- wrap_len, in, 4, wrap period of 2^wrap_len bursts.
- m_axi_arid / araddr / arlen / arsize / arburst, out, ID_WIDTH/ADDR_WIDTH/8/3/2, read address.
- m_axi_arvalid, out, 1, read address valid.
- m_axi_arready, in, 1, read address ready.
- m_axi_rid / rresp / rlast / rvalid, in, ID_WIDTH/2/1/1, read response.
- m_axi_rdata, in, DATA_WIDTH, read data; not checked.
- m_axi_rready, out, 1, read data ready.
- busy, out, 1, run in progress.
- outstanding, out, log2(MAX_OUTSTANDING)+1, bursts currently in flight.
- rd_done_pulse, out, 1, run complete.
- rd_error, out, 2, bit0 = bad RRESP, bit1 = protocol error.
- rd_error_info, out, 64, details of the first error.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-004 IDLE + engine_start_pulse SHALL capture all configuration inputs, clear the error outputs, clear the counters, and enter ISSUE; a start pulse outside IDLE SHALL be ignored.
REQ-005 rd_number==0 at start SHALL go to DONE on the next cycle, with no AR issued.
REQ-006 In ISSUE, arvalid SHALL assert when a free ID exists and issued<rd_number.
REQ-007 arid SHALL be the lowest free ID from the registered free bitmap, in the range 0..MAX_OUTSTANDING-1.
REQ-008 While arvalid=1 and arready=0, all AR fields SHALL hold stable.
REQ-009 arlen SHALL equal burst_len; arsize SHALL equal log2(DATA_WIDTH/8); arburst SHALL be 2'b01 (INCR).
REQ-010 araddr SHALL be source_address + k*(burst_len+1)*(DATA_WIDTH/8), in ADDR_WIDTH modular arithmetic.
- k = issued count when wrap_mode=0.
- k = issued mod 2^wrap_len when wrap_mode=1.
REQ-011 An AR handshake SHALL mark its ID busy, clear that ID's beat counter, and increment both issued and outstanding.
REQ-012 m_axi_rready SHALL be 1 in every state out of reset, so the engine never stalls the R channel.
REQ-013 Each R beat (rvalid & rready) to an in-flight ID SHALL increment that ID's 8-bit beat counter.
REQ-014 A beat with rlast=1 SHALL:
- free its ID and decrement outstanding;
- set rd_error[1] if the beat count before this beat differs from burst_len.
REQ-015 Any beat with rresp!=0 SHALL set rd_error[0].
REQ-016 A beat whose rid is not in flight, or is >= MAX_OUTSTANDING, SHALL set rd_error[1] and change no counter.
REQ-017 rd_error_info SHALL latch {rid zero-extended to 16 bits, rresp zero-extended to 16 bits, issued count at 32 bits} on the first error only; error outputs SHALL be sticky until the next start.
REQ-018 An AR handshake and an rlast in the same cycle SHALL leave outstanding unchanged. An ID released in cycle N SHALL first be allocatable in cycle N+1.
REQ-019 ISSUE SHALL go to DRAIN when issued==rd_number.
REQ-020 DRAIN SHALL go to DONE when outstanding==0.
REQ-021 DONE SHALL assert rd_done_pulse for exactly 1 cycle and then return to IDLE.
REQ-022 busy SHALL be 1 in ISSUE and DRAIN only.
REQ-023 Errors SHALL NOT abort a run.

Reset
REQ-024 rst SHALL put the FSM in IDLE and set outputs as follows:
- arvalid=0, busy=0, rd_done_pulse=0, rd_error=0, rd_error_info=0, outstanding=0;
- all IDs free; all counters 0; m_axi_rready=1.
REQ-025 rst asserted mid-run SHALL abandon all in-flight bursts without a done pulse. R beats arriving after reset SHALL be accepted and ignored, flagging no error.

Verification
REQ-026 The bench SHALL cover the following scenarios.
- Basic run: DATA_WIDTH=1024, source 0x1000, burst_len=1, rd_number=4, arready=1, in-order responses -> araddr 0x1000/0x1100/0x1200/0x1300; one rd_done_pulse; rd_error=0.
- Wrap run: wrap_mode=1, wrap_len=1, rd_number=5, burst_len=0 -> araddr 0x1000/0x1080/0x1000/0x1080/0x1000.
- ID exhaustion: MAX_OUTSTANDING=8, rd_number=12, slave withholds R -> exactly 8 ARs with IDs 0..7, then arvalid=0; releasing ID 3 -> next AR uses arid=3 one cycle later.
- Bad responses: rresp=2'b10 on burst 2 -> rd_error=2'b01, rd_error_info[47:32]=2; run still completes. Short burst (rlast on beat 0 with burst_len=3) -> rd_error[1]=1.
- Simultaneous events: AR handshake and rlast in the same cycle -> outstanding unchanged; stray rid=0x1F -> rd_error[1]=1.
- Edge cases: rd_number=0 -> rd_done_pulse exactly 2 cycles after start, no arvalid; rst during DRAIN -> all outputs at reset values next cycle, no rd_done_pulse.
